// File: rtl/mdu_ctrl_if.sv
// Bus between the EX stage and the multiply/divide unit.
// The EX stage (master) drives the operation strobe and operands.
// The unit (slave) returns busy, the HI/LO registers and the mf read data.
interface mdu_ctrl_if;
    logic        mdu_en;
    logic [3:0]  mdu_op;
    logic [31:0] A1;
    logic [31:0] A2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_res;

    modport master (
        output mdu_en,
        output mdu_op,
        output A1,
        output A2,
        input  busy,
        input  hi,
        input  lo,
        input  mdu_res
    );

    modport slave (
        input  mdu_en,
        input  mdu_op,
        input  A1,
        input  A2,
        output busy,
        output hi,
        output lo,
        output mdu_res
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit with HI/LO ownership and fixed-latency sequencing.
// The full result is computed when an operation is accepted and parked in
// pending registers.  A down-counter then models the pipeline latency.
// HI/LO are committed when the counter expires, so the hazard unit can use
// busy to stall later MD instructions.
module mdu_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic         clk,
    input  logic         reset,
    mdu_ctrl_if.slave    bus
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    // Unsigned divide returning {remainder, quotient}; a zero divisor yields
    // zero here because that result is never committed.
    function automatic logic [63:0] udivmod(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) begin
            return 64'd0;
        end else begin
            return {a % b, a / b};
        end
    endfunction

    // Signed divide built on magnitudes: quotient truncates toward zero and
    // the remainder follows the dividend's sign.  0x80000000 / -1 naturally
    // gives quotient 0x80000000 and remainder 0 with this construction.
    function automatic logic [63:0] sdivmod(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        logic [63:0] qr;
        mag_a = a[31] ? (32'd0 - a) : a;
        mag_b = b[31] ? (32'd0 - b) : b;
        qr    = udivmod(mag_a, mag_b);
        quo   = qr[31:0];
        rem   = qr[63:32];
        if (a[31] ^ b[31]) begin
            quo = 32'd0 - quo;
        end else begin
            quo = quo;
        end
        if (a[31]) begin
            rem = 32'd0 - rem;
        end else begin
            rem = rem;
        end
        return {rem, quo};
    endfunction

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        busy_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] pend_hi_r;
    logic [31:0] pend_lo_r;
    logic        pend_dz_r;

    logic        start_s;
    logic        is_div_s;
    logic        div_zero_s;
    logic [63:0] smul_s;
    logic [63:0] umul_s;
    logic [63:0] sdiv_s;
    logic [63:0] udiv_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    state_t      launch_state_s;
    logic [3:0]  launch_cnt_s;
    logic [31:0] mdu_res_s;

    // Decode the incoming op and compute the full result it would produce.
    always_comb begin
        start_s        = 1'b0;
        is_div_s       = 1'b0;
        res_hi_s       = 32'd0;
        res_lo_s       = 32'd0;
        smul_s         = {{32{bus.A1[31]}}, bus.A1} * {{32{bus.A2[31]}}, bus.A2};
        umul_s         = {32'd0, bus.A1} * {32'd0, bus.A2};
        sdiv_s         = sdivmod(bus.A1, bus.A2);
        udiv_s         = udivmod(bus.A1, bus.A2);
        case (bus.mdu_op)
            OP_MULT: begin
                start_s  = bus.mdu_en;
                res_hi_s = smul_s[63:32];
                res_lo_s = smul_s[31:0];
            end
            OP_MULTU: begin
                start_s  = bus.mdu_en;
                res_hi_s = umul_s[63:32];
                res_lo_s = umul_s[31:0];
            end
            OP_DIV: begin
                start_s  = bus.mdu_en;
                is_div_s = 1'b1;
                res_hi_s = sdiv_s[63:32];
                res_lo_s = sdiv_s[31:0];
            end
            OP_DIVU: begin
                start_s  = bus.mdu_en;
                is_div_s = 1'b1;
                res_hi_s = udiv_s[63:32];
                res_lo_s = udiv_s[31:0];
            end
            default: begin
                start_s  = 1'b0;
            end
        endcase
        div_zero_s = is_div_s && (bus.A2 == 32'd0);
        if (is_div_s) begin
            launch_state_s = ST_DIV;
            launch_cnt_s   = DIV_LOAD;
        end else begin
            launch_state_s = ST_MUL;
            launch_cnt_s   = MUL_LOAD;
        end
    end

    // Sequencing FSM: launches operations, counts latency, commits HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            busy_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_dz_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r   <= launch_state_s;
                        cnt_r     <= launch_cnt_s;
                        busy_r    <= 1'b1;
                        pend_hi_r <= res_hi_s;
                        pend_lo_r <= res_lo_s;
                        pend_dz_r <= div_zero_s;
                    end else if (bus.mdu_en && (bus.mdu_op == OP_MTHI)) begin
                        hi_r <= bus.A1;
                    end else if (bus.mdu_en && (bus.mdu_op == OP_MTLO)) begin
                        lo_r <= bus.A1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_r == 4'd0) begin
                        // Completion edge: commit, then either chain a new
                        // start issued on this same edge or fall back to idle.
                        if (!pend_dz_r) begin
                            hi_r <= pend_hi_r;
                            lo_r <= pend_lo_r;
                        end else begin
                            hi_r <= hi_r;
                        end
                        if (start_s) begin
                            state_r   <= launch_state_s;
                            cnt_r     <= launch_cnt_s;
                            busy_r    <= 1'b1;
                            pend_hi_r <= res_hi_s;
                            pend_lo_r <= res_lo_s;
                            pend_dz_r <= div_zero_s;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // mf read path: combinational select of HI/LO by op, independent of busy.
    always_comb begin
        mdu_res_s = 32'd0;
        case (bus.mdu_op)
            OP_MFHI: mdu_res_s = hi_r;
            OP_MFLO: mdu_res_s = lo_r;
            default: mdu_res_s = 32'd0;
        endcase
    end

    assign bus.busy    = busy_r;
    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;
    assign bus.mdu_res = mdu_res_s;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a table of single operations with
// hand-computed HI/LO and busy lengths, plus directed multi-cycle sequences.
module tb_mdu_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a1;
        logic [31:0] a2;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one operation at a negedge, then count busy cycles (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a1,
                          input logic [31:0] a2, output int busy_cnt);
        bus.mdu_en = 1'b1;
        bus.mdu_op = op;
        bus.A1     = a1;
        bus.A2     = a2;
        @(posedge clk);
        @(negedge clk);
        bus.mdu_en = 1'b0;
        bus.mdu_op = 4'd0;
        busy_cnt   = 0;
        while (bus.busy === 1'b1 && busy_cnt < 40) begin
            busy_cnt++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        bus.mdu_en = 1'b0;
        bus.mdu_op = 4'd0;
        bus.A1     = 32'd0;
        bus.A2     = 32'd0;

        vecs[0]  = '{"mthi",        4'd7, 32'h0000_1234, 32'h0,         0,  32'h0000_1234, 32'h0000_0000};
        vecs[1]  = '{"mtlo",        4'd8, 32'h0000_5678, 32'h0,         0,  32'h0000_1234, 32'h0000_5678};
        vecs[2]  = '{"divu_by0",    4'd4, 32'h0000_0007, 32'h0,         10, 32'h0000_1234, 32'h0000_5678};
        vecs[3]  = '{"nop_op0",     4'd0, 32'hAAAA_AAAA, 32'h1,         0,  32'h0000_1234, 32'h0000_5678};
        vecs[4]  = '{"nop_op9",     4'd9, 32'hAAAA_AAAA, 32'h1,         0,  32'h0000_1234, 32'h0000_5678};
        vecs[5]  = '{"mult_m1m1",   4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'h0000_0000, 32'h0000_0001};
        vecs[6]  = '{"multu_big",   4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[7]  = '{"div_neg7",    4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[8]  = '{"div_ovf",     4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[9]  = '{"divu_7_2",    4'd4, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003};
        vecs[10] = '{"div_7_m2",    4'd3, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[11] = '{"mult_negpos", 4'd1, 32'h0001_0000, 32'hFFFF_0000, 5,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{"multu_2p62",  4'd2, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000};

        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a1, vecs[i].a2, n);
            check({vecs[i].name, "_cycles"}, n, vecs[i].cycles);
            check({vecs[i].name, "_hi"}, bus.hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, bus.lo, vecs[i].exp_lo);
            if (i == 2) begin
                bus.mdu_op = 4'd5;
                #1;
                check("mfhi_res", bus.mdu_res, 32'h0000_1234);
                bus.mdu_op = 4'd6;
                #1;
                check("mflo_res", bus.mdu_res, 32'h0000_5678);
                bus.mdu_op = 4'd0;
                #1;
                check("none_res", bus.mdu_res, 32'h0000_0000);
            end
        end

        // Back-to-back: div started on the multu completion edge.
        bus.mdu_en = 1'b1; bus.mdu_op = 4'd2; bus.A1 = 32'hFFFF_FFFF; bus.A2 = 32'd2;
        @(posedge clk); @(negedge clk);
        bus.mdu_en = 1'b0; bus.mdu_op = 4'd0;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
        end
        check("b2b_busy_last", {31'd0, bus.busy}, 32'd1);
        bus.mdu_en = 1'b1; bus.mdu_op = 4'd3; bus.A1 = 32'd7; bus.A2 = 32'd2;
        @(posedge clk); @(negedge clk);
        bus.mdu_en = 1'b0; bus.mdu_op = 4'd0;
        check("b2b_mul_hi", bus.hi, 32'h0000_0001);
        check("b2b_mul_lo", bus.lo, 32'hFFFF_FFFE);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); @(negedge clk);
        end
        check("b2b_div_cycles", n, 10);
        check("b2b_div_hi", bus.hi, 32'h0000_0001);
        check("b2b_div_lo", bus.lo, 32'h0000_0003);

        // mthi issued during a mult must be ignored.
        bus.mdu_en = 1'b1; bus.mdu_op = 4'd1; bus.A1 = 32'd3; bus.A2 = 32'd4;
        @(posedge clk); @(negedge clk);
        bus.mdu_en = 1'b0; bus.mdu_op = 4'd0;
        @(posedge clk); @(negedge clk);
        bus.mdu_en = 1'b1; bus.mdu_op = 4'd7; bus.A1 = 32'h0000_DEAD;
        @(posedge clk); @(negedge clk);
        bus.mdu_en = 1'b0; bus.mdu_op = 4'd0;
        check("mthi_busy_hi", bus.hi, 32'h0000_0001);
        n = 2;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); @(negedge clk);
        end
        check("mthi_busy_cycles", n, 5);
        check("mthi_busy_final_hi", bus.hi, 32'h0000_0000);
        check("mthi_busy_final_lo", bus.lo, 32'h0000_000C);

        // Asynchronous reset in the middle of a divide.
        bus.mdu_en = 1'b1; bus.mdu_op = 4'd3; bus.A1 = 32'd100; bus.A2 = 32'd3;
        @(posedge clk); @(negedge clk);
        bus.mdu_en = 1'b0; bus.mdu_op = 4'd0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        check("rst_mid_busy_before", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid_hi", bus.hi, 32'd0);
        check("rst_mid_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(4'd8, 32'd5, 32'd0, n);
        check("post_rst_mtlo_lo", bus.lo, 32'd5);
        check("post_rst_mtlo_busy", n, 0);
        repeat (12) begin
            @(posedge clk); @(negedge clk);
        end
        check("post_rst_hi_kept", bus.hi, 32'd0);
        check("post_rst_lo_kept", bus.lo, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit with its sequencing controller for the P6 pipelined core. It sits in the EX stage beside the ALU and owns the HI/LO register pair. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations and models fixed multi-cycle latency through a busy state machine. It exposes `busy` so the hazard unit can stall subsequent MD instructions in ID.

## Interface
Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately when low
- mdu_en  input  1  operation valid strobe, sampled on the rising edge
- mdu_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none
- A1  input  32  rs operand (dividend, multiplicand, mt source)
- A2  input  32  rt operand (divisor, multiplier)
- busy  output  1  high while a mult/div is in flight
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register
- mdu_res  output  32  combinational read: hi for op 5, lo for op 6, else 0

## Operation
- States: IDLE, MUL, DIV. A 4-bit down-counter `cnt` runs in MUL and DIV.
- Reset (reset=0): the state goes to IDLE, cnt=0, hi=0, lo=0, busy=0, and pending results are cleared. This takes effect asynchronously, including in the middle of an operation. The in-flight result is discarded.
- IDLE, mdu_en=1, op 1–4:
  - The full result is computed from A1/A2 at the sampling edge and captured into pending_hi/pending_lo.
  - The state goes to MUL with cnt=MUL_CYCLES-1, or to DIV with cnt=DIV_CYCLES-1.
- mult: {hi,lo} = signed 64-bit product. multu: {hi,lo} = unsigned 64-bit product.
- div: lo = quotient, truncated toward zero; hi = remainder, which takes the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (A2=0, op 3 or 4): the unit still goes busy for DIV_CYCLES. On completion, hi and lo are left unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- MUL/DIV: cnt decrements each edge. On the edge where cnt==0, hi/lo load the pending values (except the divide-by-zero case) and the state returns to IDLE.
- op 7 (mthi) / op 8 (mtlo) with mdu_en in IDLE: hi or lo is set to A1 at that edge. Single cycle; busy is not raised.
- Any mdu_en while in MUL/DIV is ignored, including mt writes. The hazard unit guarantees none arrive; the verifier checks that hi/lo are unaffected.
- mdu_res is purely combinational from the current hi/lo and mdu_op. It ignores mdu_en and busy.

## Timing
- busy is registered and equals (state != IDLE).
- Start sampled at edge T:
  - busy=1 during cycles T..T+N-1, where N=MUL_CYCLES or DIV_CYCLES.
  - hi/lo update at edge T+N; busy=0 from that same edge.
- Back-to-back: a new start is accepted on edge T+N, the same edge busy falls. A new start is not accepted earlier.
- mthi/mtlo: the value is visible on hi/lo one edge after the strobe. mfhi in the following cycle returns the new value.
- The hazard unit stalls an MD instruction in ID when (EX holds a start op) or busy. This is documented for integration only; the logic does not live in this block.
- Reset asserted mid-operation: busy=0 and hi=lo=0 immediately, without waiting for an edge. After reset releases, the first edge is an ordinary IDLE cycle.

## Test plan
- mult, A1=0xFFFFFFFF, A2=0xFFFFFFFF -> busy high for exactly 5 cycles; then hi=0x00000000, lo=0x00000001.
- multu, A1=0xFFFFFFFF, A2=2 -> after 5 cycles, hi=0x00000001, lo=0xFFFFFFFE. Back-to-back div 7/2 started on the completion edge -> after 10 more cycles, lo=3, hi=1.
- div, A1=0xFFFFFFF9 (-7), A2=2 -> after 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload with mthi 0x1234, mtlo 0x5678; then divu A1=7, A2=0 -> busy for 10 cycles; then hi=0x1234, lo=0x5678. mfhi/mflo return these on mdu_res.
- During a mult, issue mthi A1=0xDEAD at busy cycle 2 -> ignored; the final hi/lo equal the product only.
- Start a div, drive reset=0 at busy cycle 4 between edges -> busy, hi and lo are 0 before the next edge. After release, mtlo 5 gives lo=5 one edge later.
